// File: rtl/spu_pkg.sv
// Shared SPU issue-stage types and widths.
// The widths are fixed by the SPU ISA.
package spu_pkg;

    localparam int NUM_REGS = 128;
    localparam int DATA_W   = 128;
    localparam int OP_W     = 11;
    localparam int IMM_W    = 18;
    localparam int ADDR_W   = 7;
    localparam int FMT_W    = 3;

    localparam logic [0:OP_W-1]  NOP_OP     = '0;
    localparam logic [FMT_W-1:0] NOP_FORMAT = '0;

    typedef struct packed {
        logic [0:OP_W-1]   op;
        logic [FMT_W-1:0]  format;
        logic [0:ADDR_W-1] rt_addr;
        logic [0:IMM_W-1]  imm;
        logic              reg_write;
    } issue_t;

    localparam issue_t NOP_ISSUE = '{
        op:        NOP_OP,
        format:    NOP_FORMAT,
        rt_addr:   '0,
        imm:       '0,
        reg_write: 1'b0
    };

endpackage

// File: rtl/spu_hazard_detect.sv
// Checks the RAW hazard between the issuing instruction's sources and the in-flight destinations.
// Purely combinational. The pipe delay registers serve as the scoreboard.
module spu_hazard_detect
    import spu_pkg::*;
(
    input  logic                   uses_ra_i,
    input  logic                   uses_rb_i,
    input  logic [0:ADDR_W-1]      ra_addr_i,
    input  logic [0:ADDR_W-1]      rb_addr_i,
    input  logic [0:ADDR_W-1]      out_rt_addr_i,
    input  logic                   out_reg_write_i,
    input  logic [3:0][0:ADDR_W-1] rt_addr_delay_i,
    input  logic [3:0]             reg_write_delay_i,
    output logic                   hazard_o
);

    logic ra_hit;
    logic rb_hit;
    logic unused_stage3;

    // Stage 3 retires into writeback in the same cycle, so the read bypass covers it.
    assign unused_stage3 = ^{rt_addr_delay_i[3], reg_write_delay_i[3]};

    always_comb begin
        ra_hit = out_reg_write_i && (ra_addr_i == out_rt_addr_i);
        rb_hit = out_reg_write_i && (rb_addr_i == out_rt_addr_i);
        for (int k = 0; k < 3; k++) begin
            ra_hit = ra_hit || (reg_write_delay_i[k] && (ra_addr_i == rt_addr_delay_i[k]));
            rb_hit = rb_hit || (reg_write_delay_i[k] && (rb_addr_i == rt_addr_delay_i[k]));
        end
        hazard_o = (uses_ra_i && ra_hit) || (uses_rb_i && rb_hit);
    end

endmodule

// File: rtl/spu_rf_issue.sv
// Register-fetch/issue stage: holds the 128x128 register file, bypasses writeback into reads,
// stalls on RAW hazards and registers the instruction that is handed to the SimpleFixed2 pipe.
module spu_rf_issue
    import spu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:OP_W-1]        in_op,
    input  logic [FMT_W-1:0]       in_format,
    input  logic [0:ADDR_W-1]      in_rt_addr,
    input  logic [0:ADDR_W-1]      in_ra_addr,
    input  logic [0:ADDR_W-1]      in_rb_addr,
    input  logic                   in_uses_ra,
    input  logic                   in_uses_rb,
    input  logic [0:IMM_W-1]       in_imm,
    input  logic                   in_reg_write,
    input  logic                   flush,
    input  logic [0:DATA_W-1]      rt_wb,
    input  logic [0:ADDR_W-1]      rt_addr_wb,
    input  logic                   reg_write_wb,
    input  logic [3:0][0:ADDR_W-1] rt_addr_delay,
    input  logic [3:0]             reg_write_delay,
    output logic [0:OP_W-1]        op,
    output logic [FMT_W-1:0]       format,
    output logic [0:ADDR_W-1]      rt_addr,
    output logic [0:IMM_W-1]       imm,
    output logic                   reg_write,
    output logic [0:DATA_W-1]      ra,
    output logic [0:DATA_W-1]      rb,
    output logic [31:0]            stall_count
);

    logic [0:DATA_W-1] rf_q [NUM_REGS];
    issue_t            issue_q, issue_d;
    logic [0:DATA_W-1] ra_q, ra_d;
    logic [0:DATA_W-1] rb_q, rb_d;
    logic [31:0]       stall_count_q, stall_count_d;
    logic [0:DATA_W-1] ra_val;
    logic [0:DATA_W-1] rb_val;
    logic              hazard;
    logic              accept;

    spu_hazard_detect u_hazard (
        .uses_ra_i         (in_uses_ra),
        .uses_rb_i         (in_uses_rb),
        .ra_addr_i         (in_ra_addr),
        .rb_addr_i         (in_rb_addr),
        .out_rt_addr_i     (issue_q.rt_addr),
        .out_reg_write_i   (issue_q.reg_write),
        .rt_addr_delay_i   (rt_addr_delay),
        .reg_write_delay_i (reg_write_delay),
        .hazard_o          (hazard)
    );

    assign in_ready = !hazard && !flush;
    assign accept   = in_valid && in_ready;

    // A reader in the same cycle as the writeback sees the new value.
    assign ra_val = (reg_write_wb && (rt_addr_wb == in_ra_addr)) ? rt_wb : rf_q[in_ra_addr];
    assign rb_val = (reg_write_wb && (rt_addr_wb == in_rb_addr)) ? rt_wb : rf_q[in_rb_addr];

    always_comb begin
        issue_d       = NOP_ISSUE;
        ra_d          = '0;
        rb_d          = '0;
        stall_count_d = stall_count_q;
        if (accept) begin
            issue_d = '{
                op:        in_op,
                format:    in_format,
                rt_addr:   in_rt_addr,
                imm:       in_imm,
                reg_write: in_reg_write
            };
            ra_d = ra_val;
            rb_d = rb_val;
        end
        if (in_valid && hazard && !flush && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
            issue_q       <= NOP_ISSUE;
            ra_q          <= '0;
            rb_q          <= '0;
            stall_count_q <= '0;
        end else begin
            if (reg_write_wb) begin
                rf_q[rt_addr_wb] <= rt_wb;
            end
            issue_q       <= issue_d;
            ra_q          <= ra_d;
            rb_q          <= rb_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign op          = issue_q.op;
    assign format      = issue_q.format;
    assign rt_addr     = issue_q.rt_addr;
    assign imm         = issue_q.imm;
    assign reg_write   = issue_q.reg_write;
    assign ra          = ra_q;
    assign rb          = rb_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_spu_rf_issue.sv
// Bench for spu_rf_issue: a behavioural register-file/hazard model with a small pipe emulation
// predicts each output-register load; predictions are queued and compared after the edge.
module tb_spu_rf_issue;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [0:10]      in_op;
    logic [2:0]       in_format;
    logic [0:6]       in_rt_addr, in_ra_addr, in_rb_addr;
    logic             in_uses_ra, in_uses_rb;
    logic [0:17]      in_imm;
    logic             in_reg_write;
    logic             flush;
    logic [0:127]     rt_wb;
    logic [0:6]       rt_addr_wb;
    logic             reg_write_wb;
    logic [3:0][0:6]  rt_addr_delay;
    logic [3:0]       reg_write_delay;
    logic [0:10]      op;
    logic [2:0]       format;
    logic [0:6]       rt_addr;
    logic [0:17]      imm;
    logic             reg_write;
    logic [0:127]     ra, rb;
    logic [31:0]      stall_count;

    spu_rf_issue dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_op           (in_op),
        .in_format       (in_format),
        .in_rt_addr      (in_rt_addr),
        .in_ra_addr      (in_ra_addr),
        .in_rb_addr      (in_rb_addr),
        .in_uses_ra      (in_uses_ra),
        .in_uses_rb      (in_uses_rb),
        .in_imm          (in_imm),
        .in_reg_write    (in_reg_write),
        .flush           (flush),
        .rt_wb           (rt_wb),
        .rt_addr_wb      (rt_addr_wb),
        .reg_write_wb    (reg_write_wb),
        .rt_addr_delay   (rt_addr_delay),
        .reg_write_delay (reg_write_delay),
        .op              (op),
        .format          (format),
        .rt_addr         (rt_addr),
        .imm             (imm),
        .reg_write       (reg_write),
        .ra              (ra),
        .rb              (rb),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [0:10]  op;
        logic [2:0]   fmt;
        logic [0:6]   rt;
        logic [0:17]  imm;
        logic         we;
        logic [0:127] ra;
        logic [0:127] rb;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         out_m;
    exp_t         nop_m;
    logic [0:127] rf_m [128];
    logic [0:6]   dly_a [4];
    logic         dly_w [4];
    logic [31:0]  cnt_m;
    bit           man_wb;
    bit           last_acc;
    int           n_chk;
    int           n_err;
    int           bubbles;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [0:127] wb_val(input logic [0:6] a);
        return {4{32'hBEEF_0000 | {25'd0, a}}};
    endfunction

    function automatic logic busy(input logic [0:6] a);
        logic b;
        b = out_m.we && (out_m.rt == a);
        for (int k = 0; k < 3; k++) b = b || (dly_w[k] && (dly_a[k] == a));
        return b;
    endfunction

    task automatic set_instr(input logic [0:10] op_v, input logic [0:6] rt_v, input logic [0:6] ra_v,
                             input logic [0:6] rb_v, input logic ura, input logic urb, input logic we);
        in_op        = op_v;
        in_format    = op_v[8:10];
        in_rt_addr   = rt_v;
        in_ra_addr   = ra_v;
        in_rb_addr   = rb_v;
        in_uses_ra   = ura;
        in_uses_rb   = urb;
        in_imm       = {7'd0, op_v};
        in_reg_write = we;
    endtask

    task automatic step();
        exp_t         e;
        logic         haz;
        logic         acc;
        logic [0:127] va, vb;
        for (int k = 0; k < 4; k++) begin
            rt_addr_delay[k]   = dly_a[k];
            reg_write_delay[k] = dly_w[k];
        end
        if (!man_wb) begin
            reg_write_wb = dly_w[3];
            rt_addr_wb   = dly_a[3];
            rt_wb        = wb_val(dly_a[3]);
        end
        #1;
        if (reset) begin
            e        = nop_m;
            cnt_m    = '0;
            last_acc = 1'b0;
            for (int i = 0; i < 128; i++) rf_m[i] = '0;
        end else begin
            haz = (in_uses_ra && busy(in_ra_addr)) || (in_uses_rb && busy(in_rb_addr));
            chk("in_ready", 128'(in_ready), 128'(!haz && !flush));
            acc = in_valid && !haz && !flush;
            va  = (reg_write_wb && (rt_addr_wb == in_ra_addr)) ? rt_wb : rf_m[in_ra_addr];
            vb  = (reg_write_wb && (rt_addr_wb == in_rb_addr)) ? rt_wb : rf_m[in_rb_addr];
            if (acc) e = '{op: in_op, fmt: in_format, rt: in_rt_addr, imm: in_imm,
                           we: in_reg_write, ra: va, rb: vb};
            else     e = nop_m;
            if (in_valid && haz && !flush && (cnt_m != 32'hFFFF_FFFF)) cnt_m = cnt_m + 32'd1;
            if (reg_write_wb) rf_m[rt_addr_wb] = rt_wb;
            last_acc = acc;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("op",          128'(op),          128'(e.op));
        chk("format",      128'(format),      128'(e.fmt));
        chk("rt_addr",     128'(rt_addr),     128'(e.rt));
        chk("imm",         128'(imm),         128'(e.imm));
        chk("reg_write",   128'(reg_write),   128'(e.we));
        chk("ra",          128'(ra),          128'(e.ra));
        chk("rb",          128'(rb),          128'(e.rb));
        chk("stall_count", 128'(stall_count), 128'(cnt_m));
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                dly_a[k] = '0;
                dly_w[k] = 1'b0;
            end
        end else begin
            for (int k = 3; k > 0; k--) begin
                dly_a[k] = dly_a[k-1];
                dly_w[k] = dly_w[k-1];
            end
            dly_a[0] = out_m.rt;
            dly_w[0] = out_m.we;
        end
        out_m = e;
    endtask

    task automatic run_until_accept(input string tag);
        bubbles = 0;
        step();
        for (int i = 0; i < 10 && !last_acc; i++) begin
            bubbles++;
            step();
        end
        chk(tag, 128'(last_acc), 128'(1));
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        flush    = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        nop_m = '{op: '0, fmt: '0, rt: '0, imm: '0, we: 1'b0, ra: '0, rb: '0};
        out_m = nop_m;
        cnt_m = '0;
        for (int i = 0; i < 128; i++) rf_m[i] = '0;
        for (int k = 0; k < 4; k++) begin
            dly_a[k] = '0;
            dly_w[k] = 1'b0;
        end
        man_wb       = 1'b1;
        reset        = 1'b1;
        in_valid     = 1'b0;
        flush        = 1'b0;
        reg_write_wb = 1'b0;
        rt_addr_wb   = '0;
        rt_wb        = '0;
        set_instr(11'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        #1;
        step();
        step();
        reset = 1'b0;

        // Put data in R7, then a one-cycle reset with a concurrent writeback to R5.
        reg_write_wb = 1'b1; rt_addr_wb = 7'd7; rt_wb = {4{32'h1111_2222}};
        step();
        reset = 1'b1; rt_addr_wb = 7'd5; rt_wb = {4{32'h3333_4444}};
        step();
        reset = 1'b0; reg_write_wb = 1'b0;
        set_instr(11'd1, 7'd1, 7'd7, 7'd5, 1'b1, 1'b1, 1'b0);
        in_valid = 1'b1;
        step();
        chk("rst_ra_r7", 128'(ra), 128'(0));
        chk("rst_rb_r5", 128'(rb), 128'(0));
        in_valid = 1'b0;

        // Writeback R5, read it on the following cycle.
        reg_write_wb = 1'b1; rt_addr_wb = 7'd5; rt_wb = 128'h0123456789ABCDEF0123456789ABCDEF;
        step();
        reg_write_wb = 1'b0;
        set_instr(11'd2, 7'd2, 7'd5, 7'd0, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        step();
        chk("wb_then_read", 128'(ra), 128'h0123456789ABCDEF0123456789ABCDEF);

        // Writeback and read of R5 in the same cycle.
        reg_write_wb = 1'b1; rt_addr_wb = 7'd5; rt_wb = 128'hFEDCBA9876543210_55AA55AA33CC33CC;
        set_instr(11'd3, 7'd3, 7'd5, 7'd5, 1'b1, 1'b1, 1'b0);
        step();
        chk("wb_same_cycle", 128'(ra), 128'hFEDCBA9876543210_55AA55AA33CC33CC);
        reg_write_wb = 1'b0;
        drain(2);

        // RAW through the pipe emulation: rb path then ra path, four bubbles each.
        man_wb = 1'b0;
        for (int s = 0; s < 2; s++) begin
            set_instr(11'd16 + 11'(s), 7'd10 + 7'(s), 7'd1, 7'd2, 1'b0, 1'b0, 1'b1);
            in_valid = 1'b1;
            step();
            if (s == 0) set_instr(11'd20, 7'd3, 7'd1, 7'd10, 1'b0, 1'b1, 1'b0);
            else        set_instr(11'd21, 7'd3, 7'd11, 7'd2, 1'b1, 1'b0, 1'b0);
            run_until_accept("raw_accept");
            chk("raw_bubbles", 128'(bubbles), 128'(4));
            if (s == 0) chk("raw_rb_bypass", 128'(rb), 128'(wb_val(7'd10)));
            else        chk("raw_ra_bypass", 128'(ra), 128'(wb_val(7'd11)));
            chk("raw_stall_total", 128'(stall_count), 128'(4 * (s + 1)));
            drain(5);
        end

        // No false hazards: unused source, or producer that does not write.
        set_instr(11'd30, 7'd12, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1;
        step();
        set_instr(11'd31, 7'd4, 7'd12, 7'd12, 1'b0, 1'b0, 1'b0);
        step();
        chk("nofalse_unused", 128'(last_acc), 128'(1));
        drain(5);
        set_instr(11'd32, 7'd13, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        step();
        set_instr(11'd33, 7'd4, 7'd0, 7'd13, 1'b0, 1'b1, 1'b0);
        step();
        chk("nofalse_nowrite", 128'(last_acc), 128'(1));
        drain(2);

        // Flush drops the presented instruction; the next one issues.
        set_instr(11'd40, 7'd4, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1; flush = 1'b1;
        step();
        chk("flush_ready", 128'(in_ready), 128'(0));
        chk("flush_nop_op", 128'(op), 128'(0));
        flush = 1'b0;
        set_instr(11'd41, 7'd6, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("after_flush_op", 128'(op), 128'(41));
        drain(2);

        // Flush during a hazard must not count as a stall.
        set_instr(11'd42, 7'd14, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1;
        step();
        set_instr(11'd43, 7'd6, 7'd14, 7'd0, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        run_until_accept("flush_haz_accept");
        chk("flush_haz_bubbles", 128'(bubbles), 128'(3));
        drain(5);

        // Reset in the middle of a stall clears everything in flight.
        set_instr(11'd50, 7'd16, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1;
        step();
        set_instr(11'd51, 7'd6, 7'd0, 7'd16, 1'b0, 1'b1, 1'b0);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("post_reset_accept", 128'(last_acc), 128'(1));
        chk("post_reset_count", 128'(stall_count), 128'(0));
        drain(2);

        // Saturation: preload near the top, then stall.
        set_instr(11'd60, 7'd15, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1;
        step();
        force dut.stall_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count_q;
        cnt_m = 32'hFFFF_FFFE;
        set_instr(11'd61, 7'd6, 7'd0, 7'd15, 1'b0, 1'b1, 1'b0);
        run_until_accept("sat_accept");
        chk("sat_count", 128'(stall_count), 128'(32'hFFFF_FFFF));
        drain(5);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/spu_rf_issue.md
# spu_rf_issue

Register-fetch/issue stage feeding the SimpleFixed2 execution pipe. Accepts decoded instructions from decode, reads a 128 x 128-bit register file, and commits the pipe's writeback. Detects read-after-write hazards against in-flight pipe destinations, inserting nop bubbles until the source value can be bypassed from writeback. Drives the pipe's RF/FWD inputs from an output register.

## Interface
- No parameters. Widths are fixed by the SPU ISA: 128 registers, 128-bit data, 11-bit op, 18-bit imm.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  instruction accepted this cycle (in_valid & in_ready)
- in_op  in  [0:10]  decoded opcode
- in_format  in  [2:0]  instruction format
- in_rt_addr, in_ra_addr, in_rb_addr  in  [0:6]  destination and source register addresses
- in_uses_ra, in_uses_rb  in  1  source actually read (hazard check enable)
- in_imm  in  [0:17]  immediate
- in_reg_write  in  1  instruction writes rt
- flush  in  1  branch taken: discard in_* this cycle and bubble output
- rt_wb  in  [0:127]  writeback value from pipe
- rt_addr_wb  in  [0:6]  writeback address
- reg_write_wb  in  1  writeback enable
- rt_addr_delay  in  [3:0][0:6]  pipe in-flight destinations
- reg_write_delay  in  [3:0]  pipe in-flight write enables
- op, format, rt_addr, imm, reg_write  out  same widths as in_*  registered instruction to pipe
- ra, rb  out  [0:127]  registered operand values to pipe
- stall_count  out  [31:0]  saturating count of hazard-stall cycles

## Operation
- Register file: 128 entries x 128 bits, one write port, two read ports. When reg_write_wb=1, write rt_wb into entry rt_addr_wb at the clock edge.
- Read bypass: when reading address X while reg_write_wb=1 and rt_addr_wb==X, return rt_wb rather than the stored entry.
- Hazard: a source S (enabled by in_uses_*) conflicts when either condition holds:
  - S matches the output register's rt_addr while reg_write=1.
  - S matches rt_addr_delay[k] while reg_write_delay[k]=1, for k in 0..2.
- A match on stage 3 is not a hazard; the writeback bypass covers it.
- in_ready = !hazard & !flush. in_ready is combinational and does not depend on in_valid.
- Each cycle the output register loads one of:
  - the accepted instruction, with bypassed ra/rb, when in_valid & in_ready;
  - otherwise a nop: op=0, format=0, rt_addr=0, imm=0, reg_write=0, ra=rb=0.
- flush has priority over hazard. The in_* instruction is dropped and decode must re-present the correct path.
- stall_count increments on each cycle with in_valid & hazard & !flush, and saturates at 32'hFFFFFFFF.
- Simultaneous writeback and read of the same address: the reader gets the new value. Writes to all 128 entries are legal; there is no hardwired zero register.

## Timing
- Reset, one cycle: all 128 entries = 0, output register = nop, stall_count = 0. in_ready=1 once the reset cycle ends.
- Issue latency: an instruction accepted in cycle t is on op/ra/rb... during cycle t+1. The pipe samples it at the end of t+1.
- Producer-to-consumer latency: a producer accepted at t and a dependent instruction presented at t+1 stall in cycles t+1..t+4, then are accepted at t+5. That is 4 bubbles; the value is bypassed from rt_wb.
- Hazard logic is pure comparison and has no state machine; the pipe delay registers act as the scoreboard.
- Asserting reset mid-stall discards everything in flight. The register file is cleared and the pipe is reset by the same signal.

## Structure
- Shared spu_pkg holds:
  - constants for register count, data width, op width and imm width;
  - NOP_OP = 0 and NOP_FORMAT = 0;
  - a packed typedef issue_t containing op, format, rt_addr, imm and reg_write.
- Sub-module spu_hazard_detect: purely combinational. Inputs are the two sources with their enables, the output register's destination, and rt_addr_delay/reg_write_delay. Output is hazard.
- The register file array, read bypass, output register and stall counter live in spu_rf_issue.

## Test plan
- Reset: assert reset for 1 cycle with reg_write_wb=1 -> all reads return 0, outputs are nop, stall_count=0, in_ready=1.
- Writeback/read: writeback R5=0x0123...EF, then issue a reader of R5 one cycle later -> ra=0x0123...EF. Writeback R5 in the same cycle as a read of R5 -> ra equals rt_wb.
- RAW stall: producer writes R10, next instruction reads rb=R10 -> exactly 4 nop cycles, then accepted. rb equals rt_wb from that cycle and stall_count=4.
- No false hazard: same sequence with in_uses_rb=0, or with the producer's reg_write=0 -> accepted in the next cycle with no bubbles.
- Flush: flush=1 with in_valid=1 -> in_ready=0, output is nop, and the instruction never appears. An instruction in the next cycle issues normally.
- Saturation: force stall_count near its maximum by holding a hazard for 2^32 cycles (or by a backdoor preload to 32'hFFFFFFFE) -> counter stops at 32'hFFFFFFFF.
